pipe_cla_adder: RTL and testbench
=================================

# pipe_cla_adder

- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the team's fixed 4-bit CLA cell.
- Splits a WIDTH-bit operation into CHUNK-bit lookahead groups, one group per pipeline stage; the carry is registered between stages.
- Valid/ready handshake with backpressure on both sides.
- Used in the ALU/EX path where wide adds must not limit cycle time.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits per lookahead group (one group per stage); STAGES = WIDTH/CHUNK, legal range 1..8.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_ci  input  1  carry-in; used only when in_sub=0.
- in_sub  input  1  1 = A − B, 0 = A + B.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  result bits.
- out_co  output  1  carry-out of bit WIDTH−1; in subtract mode 1 = no borrow.
- out_ovf  output  1  signed overflow (only with the flags feature).
- out_zero  output  1  out_sum == 0 (only with the flags feature).

## Operation
- Effective operands and carry:
  - B' = in_sub ? ~in_b : in_b.
  - c_in = in_sub ? 1 : in_ci.
- Lookahead group g (0 = LSB), bits [g*CHUNK +: CHUNK]:
  - P_i = a_i ^ b'_i; G_i = a_i & b'_i.
  - c_{i+1} = G_i | (P_i & c_i), flattened as true lookahead within the group.
  - s_i = P_i ^ c_i.
- Pipeline structure:
  - Stage k computes group k from registered upper operand bits and the carry registered out of stage k−1.
  - Already-computed lower sum bits travel forward alongside.
  - Operand bits above group k are delayed unchanged.
  - Each stage holds a valid bit.
- Global advance: adv = !out_valid | out_ready.
  - When adv=1, every stage register loads from its predecessor.
  - Stage 0 loads {in_valid, operands}.
  - When adv=0, all stage registers hold.
- in_ready = adv, combinational from out_valid and out_ready. Never depends on in_valid.
- Beats are accepted on in_valid & in_ready and transferred out on out_valid & out_ready.
- Bubbles are not compressed; an accepted beat exits exactly STAGES advancing cycles later.
- Order is strictly preserved. No beat is dropped or duplicated under any stall pattern.
- out_sum, out_co and flags are registered outputs of the last stage. They stay stable while out_valid=1 and out_ready=0.
- Arithmetic is modulo 2^WIDTH. out_co is the raw carry-out.

## Timing
- Latency: STAGES cycles from the acceptance edge to out_valid=1, with no stall.
  - Example: WIDTH=16, CHUNK=4 → beat accepted at edge N, out_valid high after edge N+4.
- Throughput: one beat per cycle while out_ready=1.
- Stall: a cycle with out_valid=1 and out_ready=0 freezes the whole pipeline; in_ready=0 that same cycle.
- Simultaneous accept and output transfer in one cycle is legal and required for full throughput.
- Reset (rst_n low, asynchronous, any time):
  - All stage valid bits clear; out_valid=0, out_sum=0, out_co=0, out_ovf=0, out_zero=0.
  - In-flight beats are discarded.
  - in_ready=1 during and after reset.
  - The first beat can be accepted on the first rising edge after rst_n deasserts.
- STAGES=1 degenerates to a single registered CLA with latency 1.

## Configuration
- PIPE_CLA_ADDER_FLAGS_EN defined:
  - out_ovf = (a_msb == b'_msb) & (sum_msb != a_msb), computed in the last stage.
  - out_zero = ~|out_sum.
  - Both are registered with the result and reset to 0.
- Not defined: out_ovf and out_zero are tied to 0; no flag logic is synthesised. Port list is unchanged.

## Test plan
- WIDTH=16, CHUNK=4; reset, then 0x00FF + 0x0001, ci=0:
  - out_sum=0x0100, co=0, four cycles after acceptance.
  - Checks the inter-stage carry.
- 0xFFFF + 0x0001, ci=0 → out_sum=0x0000, co=1. With FLAGS_EN: zero=1, ovf=0.
- Subtract, 0x0005 − 0x0007 → out_sum=0xFFFE, co=0 (borrow). Subtract 0x8000 − 0x0001 → out_sum=0x7FFF, co=1, ovf=1.
- Ten back-to-back beats A=i, B=i, with out_ready held 1 → results 2i in order, one per cycle, no gaps.
- Streaming with out_ready toggling randomly:
  - Every result matches the scoreboard, in order, with no loss.
  - out_sum is stable while stalled; in_ready == (!out_valid | out_ready) every cycle.
- Assert rst_n=0 mid-stream with three beats in flight:
  - out_valid drops immediately (asynchronously); no stale beat emerges after release.
  - The next accepted beat returns correctly after four cycles.

Source files
------------

// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder -- pipelined carry-lookahead adder/subtractor.
//
// The WIDTH-bit operation is split into CHUNK-bit lookahead groups. Each
// pipeline stage resolves one group, and the carry is registered between
// stages. Sum bits that are already resolved travel forward with the beat.
// Operand bits for higher groups are delayed unchanged until their stage.
// STAGES = WIDTH/CHUNK. WIDTH must be a multiple of CHUNK, and STAGES must
// lie in 1..8.
//
// Pipeline: register bank 0 captures the accepted operands. Stage k reads
// bank k and writes bank k+1, so bank STAGES is the output register. A beat
// accepted at edge N is presented after edge N+STAGES. A stalled output
// freezes every bank; bubbles are never squeezed out.
//
// Optional feature: define PIPE_CLA_ADDER_FLAGS_EN to build registered
// out_ovf and out_zero flags. Without it, both outputs are tied to 0.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready = !out_valid | out_ready)
//   in_a, in_b          operands
//   in_ci               carry-in (ignored when in_sub=1)
//   in_sub              1: A - B, 0: A + B
//   out_valid/out_ready result handshake
//   out_sum, out_co     result and raw carry-out (subtract: 1 = no borrow)
//   out_ovf, out_zero   signed overflow and zero flags (flags build only)

// One CHUNK-bit lookahead group. Each carry is a flat sum of products of
// the group's generate/propagate terms and the group carry-in. No carry
// ripples through the neighbouring bit's carry.
module pipe_cla_group #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  logic [CHUNK-1:0] p, g;
  logic [CHUNK:0]   c;
  logic             term;

  assign p = a ^ b;
  assign g = a & b;

  // c[i+1] = G_i | P_i G_{i-1} | ... | P_i..P_1 G_0 | P_i..P_0 ci
  always_comb begin
    c    = '0;
    term = 1'b0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
      term = ci;
      for (int m = 0; m <= i; m++) term = term & p[m];
      c[i+1] = c[i+1] | term;
    end
  end

  assign s  = p ^ c[CHUNK-1:0];
  assign co = c[CHUNK];
endmodule

module pipe_cla_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int STAGES = WIDTH / CHUNK;

  logic                         adv;
  logic [STAGES:0]              vld_pipe;  // valid bit of bank 0..STAGES
  logic [STAGES:0]              c_q;       // carry into group k held in bank k
  logic [STAGES-1:0][CHUNK-1:0] grp_s;
  logic [STAGES-1:0]            grp_co;

  // The pipeline moves as a whole. Only a held output can stop it.
  assign adv      = !vld_pipe[STAGES] | out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      c_q      <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      // Subtraction is A + ~B + 1, so a forced carry-in of 1 replaces in_ci.
      c_q      <= {grp_co, in_sub | in_ci};
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;

    // Bank k operands. Only bits from group k upward are still needed.
    logic [WIDTH-1:LO]     a_r, b_r, a_d, b_d;
    // Bank k+1 resolved sum bits (groups 0..k).
    logic [LO+CHUNK-1:0]   sum_r, sum_d;

    if (k == 0) begin : g_head
      assign a_d   = in_a;
      assign b_d   = in_sub ? ~in_b : in_b;
      assign sum_d = grp_s[k];
    end else begin : g_body
      assign a_d   = g_stage[k-1].a_r[WIDTH-1:LO];
      assign b_d   = g_stage[k-1].b_r[WIDTH-1:LO];
      assign sum_d = {grp_s[k], g_stage[k-1].sum_r};
    end

    pipe_cla_group #(.CHUNK(CHUNK)) u_grp (
      .a  (a_r[LO +: CHUNK]),
      .b  (b_r[LO +: CHUNK]),
      .ci (c_q[k]),
      .s  (grp_s[k]),
      .co (grp_co[k])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_r   <= '0;
        b_r   <= '0;
        sum_r <= '0;
      end else if (adv) begin
        a_r   <= a_d;
        b_r   <= b_d;
        sum_r <= sum_d;
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_co    = c_q[STAGES];
  assign out_sum   = g_stage[STAGES-1].sum_r;

`ifdef PIPE_CLA_ADDER_FLAGS_EN
  logic ovf_r, zero_r, a_msb, b_msb, s_msb;

  // The MSB inputs are only present in the last stage. The flags are
  // therefore formed there and registered with the sum.
  assign a_msb = g_stage[STAGES-1].a_r[WIDTH-1];
  assign b_msb = g_stage[STAGES-1].b_r[WIDTH-1];
  assign s_msb = grp_s[STAGES-1][CHUNK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (adv) begin
      ovf_r  <= (a_msb == b_msb) & (s_msb != a_msb);
      zero_r <= ~|g_stage[STAGES-1].sum_d;
    end
  end

  assign out_ovf  = ovf_r;
  assign out_zero = zero_r;
`else
  assign out_ovf  = 1'b0;
  assign out_zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Scoreboard bench for pipe_cla_adder at WIDTH=16, CHUNK=4.
// Expected results come from plain integer arithmetic.
module tb_pipe_cla_adder;
  localparam int W = 16;
  localparam int C = 4;
  localparam int S = W / C;

  typedef struct packed {
    logic         co;
    logic         ovf;
    logic         zero;
    logic [W-1:0] sum;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ci = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_co, out_ovf, out_zero;

  res_t exp_q[$];
  int   pop_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   track = 0;
  bit   held = 0;
  res_t held_v, got_v, exp_v;

  pipe_cla_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_co(out_co), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sub);
    res_t r;
    int ua, ub, ur, sa, sb, sr;
    ua = int'(a);           ub = int'(b);
    sa = int'($signed(a));  sb = int'($signed(b));
    if (sub) begin
      ur = ua - ub;  sr = sa - sb;  r.co = (ua >= ub);
    end else begin
      ur = ua + ub + int'(ci);  sr = sa + sb + int'(ci);  r.co = (ur >= (1 << W));
    end
    r.sum = ur[W-1:0];
`ifdef PIPE_CLA_ADDER_FLAGS_EN
    r.ovf  = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    r.zero = (r.sum == '0);
`else
    r.ovf  = 1'b0;
    r.zero = 1'b0;
`endif
    return r;
  endfunction

  // Monitor: checks the handshake rule and stall stability, and pops the scoreboard on each transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else begin
      got_v = {out_co, out_ovf, out_zero, out_sum};
      chk("in_ready_rule", in_ready, !out_valid | out_ready);
      if (held) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", got_v, held_v);
      end
      held   = out_valid && !out_ready;
      held_v = got_v;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %0h expected none", got_v);
        end else begin
          exp_v = exp_q.pop_front();
          chk("result", got_v, exp_v);
          if (track) pop_cyc.push_back(cyc);
        end
      end
    end
  end

  // Holds one beat on the inputs until it is accepted.
  // Returns at 1 time unit after the acceptance edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic sub);
    in_valid = 1'b1; in_a = a; in_b = b; in_ci = ci; in_sub = sub;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(a, b, ci, sub));
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    in_valid = 1'b0;
  endtask

  task automatic send_expect(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic ci, input logic sub, input logic [W-1:0] esum,
                             input logic eco, input logic eovf, input logic ezero);
    int lat;
    out_ready = 1'b1;
    send(a, b, ci, sub);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, S);
    chk({name, "_sum"}, out_sum, esum);
    chk({name, "_co"}, out_co, eco);
`ifdef PIPE_CLA_ADDER_FLAGS_EN
    chk({name, "_ovf"}, out_ovf, eovf);
    chk({name, "_zero"}, out_zero, ezero);
`else
    chk({name, "_ovf_off"}, out_ovf, 0);
    chk({name, "_zero_off"}, out_zero, 0);
    if (eovf === 1'bx || ezero === 1'bx) $display("note: flag expectation undefined");
`endif
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset, checked without any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("reset_valid", out_valid, 0);
    chk("reset_sum", out_sum, 0);
    chk("reset_co", out_co, 0);
    chk("reset_flags", {out_ovf, out_zero}, 0);
    chk("reset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    send_expect("carry_chain", 16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0, 0);
    send_expect("wrap",        16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
    send_expect("sub_borrow",  16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0, 0);
    send_expect("sub_ovf",     16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 0);
    send_expect("add_ovf",     16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
    send_expect("carry_in",    16'h000F, 16'h0000, 1, 0, 16'h0010, 0, 0, 0);
    send_expect("sub_ci_ign",  16'h0009, 16'h0009, 1, 1, 16'h0000, 1, 0, 1);
    drain();

    // Ten back-to-back beats: results 2i, in order, on consecutive cycles.
    out_ready = 1'b1;
    pop_cyc.delete();
    track = 1;
    for (int i = 0; i < 10; i++) send(W'(i), W'(i), 0, 0);
    drain();
    track = 0;
    chk("b2b_count", pop_cyc.size(), 10);
    if (pop_cyc.size() == 10) chk("b2b_gapless", pop_cyc[9] - pop_cyc[0], 9);

    // Random streaming with random backpressure.
    for (int n = 0; n < 500; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_a      = pick();
      in_b      = pick();
      in_ci     = 1'($urandom_range(0, 1));
      in_sub    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_ci, in_sub));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Reset in mid-stream. Three beats are in flight, and the head beat is stalled at the output.
    out_ready = 1'b0;
    send(16'h1111, 16'h0001, 0, 0);
    send(16'h2222, 16'h0002, 0, 0);
    send(16'h3333, 16'h0003, 0, 1);
    for (int t = 0; t < 20 && !out_valid; t++) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_stalled", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_drop_valid", out_valid, 0);
    chk("async_clear_sum", out_sum, 0);
    chk("async_in_ready", in_ready, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    send_expect("post_reset", 16'h1234, 16'h0001, 0, 0, 16'h1235, 0, 0, 0);
    @(posedge clk); #1;
    for (int t = 0; t < 8; t++) begin
      chk("no_stale_beat", out_valid, 0);
      @(posedge clk); #1;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
